serial_pe: RTL and testbench

Serial multiply-accumulate processing element: each valid cycle it takes one signed 16-bit neuron and one signed 16-bit weight and accumulates their product into a 32-bit running sum. Dot products of any length are delimited by a two-bit control field (first and last element). When the last element has been accumulated, the block emits the 32-bit result with a one-cycle valid pulse. It sits behind a streaming address generator that feeds one neuron/weight pair per clock from line buffers, and in front of result storage or comparison logic.

---
 rtl/pe_pkg.sv | 20 ++
 rtl/serial_pe_if.sv | 14 +
 rtl/pe_mul16.sv | 34 +++
 rtl/serial_pe.sv | 55 +++++
 tb/tb_serial_pe.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared widths, control-bit indices and the accumulate step for the serial MAC element.
package pe_pkg;
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 32;
    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;

    // A first element restarts the sum; otherwise add with natural modulo-2^ACC_W wrap.
    function automatic logic [ACC_W-1:0] acc_step(input logic             first,
                                                  input logic [ACC_W-1:0] acc,
                                                  input logic [ACC_W-1:0] prod);
        logic [ACC_W-1:0] next_v;
        if (first) begin
            next_v = prod;
        end else begin
            next_v = acc + prod;
        end
        return next_v;
    endfunction
endpackage

// File: rtl/serial_pe_if.sv
// Operand/result stream between the address generator (master) and the MAC element (slave).
interface serial_pe_if;
    import pe_pkg::*;

    logic signed [DATA_W-1:0] neuron;
    logic signed [DATA_W-1:0] weight;
    logic        [1:0]        ctl;
    logic                     vld_i;
    logic signed [ACC_W-1:0]  result;
    logic                     vld_o;

    modport master (output neuron, weight, ctl, vld_i, input result, vld_o);
    modport slave  (input neuron, weight, ctl, vld_i, output result, vld_o);
endinterface

// File: rtl/pe_mul16.sv
// Registered signed 16x16->32 multiplier; vld/ctl ride along so control stays aligned with the product.
module pe_mul16
    import pe_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     vld_i,
    input  logic        [1:0]        ctl_i,
    output logic signed [ACC_W-1:0]  prod,
    output logic                     vld_o,
    output logic        [1:0]        ctl_o
);
    logic signed [ACC_W-1:0] prod_s;

    // Operands are sign-extended to full width before multiplying.
    always_comb begin
        prod_s = ACC_W'(a) * ACC_W'(b);
    end

    // Product stage; ctl is zeroed on bubbles so stale markers never reach the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod  <= {ACC_W{1'b0}};
            vld_o <= 1'b0;
            ctl_o <= 2'b00;
        end else begin
            prod  <= prod_s;
            vld_o <= vld_i;
            ctl_o <= vld_i ? ctl_i : 2'b00;
        end
    end
endmodule

// File: rtl/serial_pe.sv
// Serial multiply-accumulate element: one product per valid cycle, result pulsed two cycles after the last element.
module serial_pe
    import pe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    serial_pe_if.slave  bus
);
    logic signed [ACC_W-1:0] prod_s;
    logic                    vld_d_s;
    logic        [1:0]       ctl_d_s;
    logic        [ACC_W-1:0] acc_next_s;
    logic        [ACC_W-1:0] acc_r;
    logic        [ACC_W-1:0] result_r;
    logic                    vld_o_r;

    pe_mul16 u_mul (
        .clk   (clk),
        .rst   (rst),
        .a     (bus.neuron),
        .b     (bus.weight),
        .vld_i (bus.vld_i),
        .ctl_i (bus.ctl),
        .prod  (prod_s),
        .vld_o (vld_d_s),
        .ctl_o (ctl_d_s)
    );

    // Next running sum for the element currently leaving the product stage.
    always_comb begin
        acc_next_s = acc_step(ctl_d_s[CTL_FIRST], acc_r, prod_s);
    end

    // Accumulator and result capture; result takes the sum that already includes the last element.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {ACC_W{1'b0}};
            result_r <= {ACC_W{1'b0}};
            vld_o_r  <= 1'b0;
        end else if (vld_d_s) begin
            acc_r <= acc_next_s;
            if (ctl_d_s[CTL_LAST]) begin
                result_r <= acc_next_s;
                vld_o_r  <= 1'b1;
            end else begin
                vld_o_r  <= 1'b0;
            end
        end else begin
            vld_o_r <= 1'b0;
        end
    end

    assign bus.result = result_r;
    assign bus.vld_o  = vld_o_r;
endmodule

// File: tb/tb_serial_pe.sv
// Bench for serial_pe: event-queue dot-product model compared every cycle, plus literal expectations.
module tb_serial_pe;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    serial_pe_if bus ();
    serial_pe dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct { int due; int val; bit last; } ev_t;
    ev_t          ev_q[$];
    int           edge_n   = 0;
    int           acc_m    = 0;
    int           result_m = 0;
    bit           vld_m    = 1'b0;
    logic [31:0]  got_q[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted element contributes to the running sum; a last element becomes visible one edge later.
    always @(posedge clk) begin
        ev_t e;
        int  p;
        edge_n++;
        if (rst) begin
            ev_q.delete();
            acc_m    = 0;
            result_m = 0;
            vld_m    = 1'b0;
        end else begin
            vld_m = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].due == edge_n) begin
                e = ev_q.pop_front();
                if (e.last) begin
                    result_m = e.val;
                    vld_m    = 1'b1;
                end
            end
            if (bus.vld_i) begin
                p     = int'(bus.neuron) * int'(bus.weight);
                acc_m = bus.ctl[0] ? p : acc_m + p;
                ev_q.push_back('{edge_n + 1, acc_m, bus.ctl[1]});
            end
        end
    end

    // Compare DUT against the model and log every pulse.
    always @(negedge clk) begin
        if (chk_en) begin
            check("vld_o", {31'b0, bus.vld_o}, {31'b0, vld_m});
            check("result", bus.result, result_m);
        end
        if (bus.vld_o === 1'b1) got_q.push_back(bus.result);
    end

    task automatic drive(bit r, bit v, logic [1:0] c, int n, int w);
        rst        = r;
        bus.vld_i  = v;
        bus.ctl    = c;
        bus.neuron = 16'(n);
        bus.weight = 16'(w);
        @(negedge clk);
    endtask

    task automatic drain(int k);
        for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), int'($urandom), int'($urandom));
    endtask

    task automatic check_pulses(string name, int n, logic [31:0] e0, logic [31:0] e1);
        check({name, "_count"}, got_q.size(), n);
        if (n >= 1) check({name, "_r0"}, (got_q.size() > 0) ? got_q[0] : 32'hDEADBEEF, e0);
        if (n >= 2) check({name, "_r1"}, (got_q.size() > 1) ? got_q[1] : 32'hDEADBEEF, e1);
        got_q.delete();
    endtask

    initial begin
        rst = 1'b1; bus.vld_i = 1'b0; bus.ctl = 2'b00; bus.neuron = 16'sd0; bus.weight = 16'sd0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_result", bus.result, 32'h0000_0000);
        check("reset_vld", {31'b0, bus.vld_o}, 32'h0000_0000);
        drain(2);
        got_q.delete();

        drive(1'b0, 1'b1, 2'b11, 3, -4);
        drain(4);
        check_pulses("single", 1, 32'hFFFF_FFF4, 32'h0);

        for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, {i == 31, i == 0}, 2, 5);
        drain(4);
        check_pulses("dot32", 1, 32'd320, 32'h0);

        for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, {i == 63, i == 0}, 1, 1);
        for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, {i == 31, i == 0}, -1, 7);
        drain(4);
        check_pulses("b2b", 2, 32'd64, 32'hFFFF_FF20);

        // 4 x 0x3FFF0001 with bubbles between elements
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, {i == 3, i == 0}, 32'h7FFF, 32'h7FFF);
            drain(i + 1);
        end
        drain(3);
        check_pulses("bubbles", 1, 32'hFFFC_0004, 32'h0);

        drive(1'b0, 1'b1, 2'b01, -32768, -32768);
        drive(1'b0, 1'b1, 2'b10, -32768, -32768);
        drain(4);
        check_pulses("wrap", 1, 32'h8000_0000, 32'h0);

        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, {1'b0, i == 0}, i + 3, 9 - i);
        drive(1'b1, 1'b1, 2'b00, 7, 7);
        check("rst_result_zero", bus.result, 32'h0000_0000);
        drain(3);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, {i == 3, i == 0}, 1, 1);
        drain(4);
        check_pulses("after_rst", 1, 32'd4, 32'h0);

        drive(1'b0, 1'b1, 2'b11, 5, 5);
        drain(10);
        drive(1'b0, 1'b1, 2'b10, 1, 3);
        drain(4);
        check_pulses("idle_ctl", 2, 32'd25, 32'd28);

        for (int s = 0; s < 60; s++) begin
            int len;
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) drain(1);
                if ($urandom_range(0, 40) == 0)
                    drive(1'b1, 1'($urandom), 2'($urandom), int'($urandom), int'($urandom));
                drive(1'b0, 1'b1, {i == len - 1, (i == 0) && ($urandom_range(0, 7) != 0)},
                      int'($urandom), int'($urandom));
            end
        end
        drain(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
